// File: rtl/sram_dual_req_arbiter_if.sv
// Requester/response channels and the 1W1R SRAM macro port of sram_dual_req_arbiter.
// slave = arbiter side; master = clients plus SRAM macro side.
interface sram_dual_req_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int MASK_W = 4
);
  logic              req0_valid, req1_valid;
  logic              req0_ready, req1_ready;
  logic              req0_write, req1_write;
  logic [ADDR_W-1:0] req0_addr,  req1_addr;
  logic [DATA_W-1:0] req0_wdata, req1_wdata;
  logic [MASK_W-1:0] req0_wmask, req1_wmask;
  logic              rsp0_valid, rsp1_valid;
  logic              rsp0_ready, rsp1_ready;
  logic [DATA_W-1:0] rsp0_rdata, rsp1_rdata;
  logic              W0_en;
  logic [ADDR_W-1:0] W0_addr;
  logic [DATA_W-1:0] W0_data;
  logic [MASK_W-1:0] W0_mask;
  logic              R0_en;
  logic [ADDR_W-1:0] R0_addr;
  logic [DATA_W-1:0] R0_data;

  modport slave (
    input  req0_valid, req1_valid, req0_write, req1_write, req0_addr, req1_addr,
           req0_wdata, req1_wdata, req0_wmask, req1_wmask, rsp0_ready, rsp1_ready, R0_data,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata,
           W0_en, W0_addr, W0_data, W0_mask, R0_en, R0_addr
  );

  modport master (
    output req0_valid, req1_valid, req0_write, req1_write, req0_addr, req1_addr,
           req0_wdata, req1_wdata, req0_wmask, req1_wmask, rsp0_ready, rsp1_ready, R0_data,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata,
           W0_en, W0_addr, W0_data, W0_mask, R0_en, R0_addr
  );
endinterface

// File: rtl/sram_dual_req_arbiter.sv
// Shares one 1W1R byte-masked SRAM between two requesters: independent write/read arbitration,
// posted writes, per-requester response FIFOs. Define SRAM_ARB_FIXED_PRIO_EN for fixed priority (req0 wins).
module sram_dual_req_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int MASK_W    = 4,
  parameter int RSP_DEPTH = 3
) (
  input  logic                   clock,
  input  logic                   reset_n,
  sram_dual_req_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  logic [1:0]        req_valid, req_write, rsp_ready;
  logic [ADDR_W-1:0] req_addr  [2];
  logic [DATA_W-1:0] req_wdata [2];
  logic [MASK_W-1:0] req_wmask [2];

  assign req_valid    = {bus.req1_valid, bus.req0_valid};
  assign req_write    = {bus.req1_write, bus.req0_write};
  assign rsp_ready    = {bus.rsp1_ready, bus.rsp0_ready};
  assign req_addr[0]  = bus.req0_addr;
  assign req_addr[1]  = bus.req1_addr;
  assign req_wdata[0] = bus.req0_wdata;
  assign req_wdata[1] = bus.req1_wdata;
  assign req_wmask[0] = bus.req0_wmask;
  assign req_wmask[1] = bus.req1_wmask;

  logic [1:0]        wr_cand, rd_cand, wr_gnt, rd_gnt;
  logic [1:0]        credit, inflight_n, push, pop;
  logic              inflight_q, inflight_d;
  logic              inflight_id_q, inflight_id_d;
  logic [CNT_W-1:0]  cnt_q    [2], cnt_d    [2];
  logic [PTR_W-1:0]  wr_ptr_q [2], wr_ptr_d [2];
  logic [PTR_W-1:0]  rd_ptr_q [2], rd_ptr_d [2];
  logic [DATA_W-1:0] fifo_mem [2][RSP_DEPTH];

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A read is only eligible while its response has a guaranteed FIFO slot, in-flight read included.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      inflight_n[n] = inflight_q && (inflight_id_q == 1'(n));
      credit[n]     = (32'(cnt_q[n]) + 32'(inflight_n[n])) < RSP_DEPTH;
    end
    wr_cand = req_valid & req_write & {2{reset_n}};
    rd_cand = req_valid & ~req_write & credit & {2{reset_n}};
  end

`ifdef SRAM_ARB_FIXED_PRIO_EN
  function automatic logic [1:0] pick(input logic [1:0] cand);
    return cand[0] ? 2'b01 : {cand[1], 1'b0};
  endfunction

  assign wr_gnt = pick(wr_cand);
  assign rd_gnt = pick(rd_cand);
`else
  logic wr_last_q, wr_last_d;
  logic rd_last_q, rd_last_d;

  // On a tie the requester that did not win last time is served.
  function automatic logic [1:0] pick(input logic [1:0] cand, input logic last);
    return (&cand) ? (last ? 2'b01 : 2'b10) : cand;
  endfunction

  assign wr_gnt = pick(wr_cand, wr_last_q);
  assign rd_gnt = pick(rd_cand, rd_last_q);

  always_comb begin
    wr_last_d = (|wr_gnt) ? wr_gnt[1] : wr_last_q;
    rd_last_d = (|rd_gnt) ? rd_gnt[1] : rd_last_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_last_q <= 1'b1;
      rd_last_q <= 1'b1;
    end else begin
      wr_last_q <= wr_last_d;
      rd_last_q <= rd_last_d;
    end
  end
`endif

  // NOTE: every output is given a default before the if-chain so no path leaves one unassigned (no latch).
  always_comb begin
    bus.W0_en   = |wr_gnt;
    bus.W0_addr = '0;
    bus.W0_data = '0;
    bus.W0_mask = '0;
    bus.R0_en   = |rd_gnt;
    bus.R0_addr = '0;
    for (int n = 0; n < 2; n++) begin
      if (wr_gnt[n]) begin
        bus.W0_addr = req_addr[n];
        bus.W0_data = req_wdata[n];
        bus.W0_mask = req_wmask[n];
      end
      if (rd_gnt[n]) bus.R0_addr = req_addr[n];
    end
    bus.req0_ready = wr_gnt[0] | rd_gnt[0];
    bus.req1_ready = wr_gnt[1] | rd_gnt[1];
  end

  // R0_data belongs to the read issued last cycle; it lands in that requester's FIFO.
  always_comb begin
    inflight_d    = |rd_gnt;
    inflight_id_d = rd_gnt[1];
    for (int n = 0; n < 2; n++) begin
      push[n]     = inflight_n[n];
      pop[n]      = (cnt_q[n] != '0) && rsp_ready[n];
      cnt_d[n]    = cnt_q[n] + CNT_W'(push[n]) - CNT_W'(pop[n]);
      wr_ptr_d[n] = push[n] ? next_ptr(wr_ptr_q[n]) : wr_ptr_q[n];
      rd_ptr_d[n] = pop[n]  ? next_ptr(rd_ptr_q[n]) : rd_ptr_q[n];
    end
  end

  always_comb begin
    bus.rsp0_valid = cnt_q[0] != '0;
    bus.rsp1_valid = cnt_q[1] != '0;
    bus.rsp0_rdata = bus.rsp0_valid ? fifo_mem[0][rd_ptr_q[0]] : '0;
    bus.rsp1_rdata = bus.rsp1_valid ? fifo_mem[1][rd_ptr_q[1]] : '0;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight_q    <= 1'b0;
      inflight_id_q <= 1'b0;
      for (int n = 0; n < 2; n++) begin
        cnt_q[n]    <= '0;
        wr_ptr_q[n] <= '0;
        rd_ptr_q[n] <= '0;
      end
    end else begin
      inflight_q    <= inflight_d;
      inflight_id_q <= inflight_id_d;
      for (int n = 0; n < 2; n++) begin
        cnt_q[n]    <= cnt_d[n];
        wr_ptr_q[n] <= wr_ptr_d[n];
        rd_ptr_q[n] <= rd_ptr_d[n];
      end
    end
  end

  // NOTE: FIFO storage is not reset; cnt_q alone marks valid entries and rdata is forced to 0 when empty.
  always_ff @(posedge clock) begin
    for (int n = 0; n < 2; n++) begin
      if (push[n]) fifo_mem[n][wr_ptr_q[n]] <= bus.R0_data;
    end
  end
endmodule

// File: tb/tb_sram_dual_req_arbiter.sv
// Directed bench for sram_dual_req_arbiter: SRAM macro model, a transaction-level reference
// model compared every cycle, and hand-computed expectations for the key scenarios.
module tb_sram_dual_req_arbiter;
  localparam int AW = 10, DW = 32, MW = 4, DEPTH = 3;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  sram_dual_req_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW)) bus ();

  sram_dual_req_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MASK_W(MW), .RSP_DEPTH(DEPTH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // SRAM macro: byte-masked write and registered read address, both at the clock edge.
  logic [DW-1:0] sram_mem [1024];
  logic [AW-1:0] sram_raddr_q = '0;
  always @(posedge clock) begin
    if (bus.W0_en)
      for (int b = 0; b < MW; b++)
        if (bus.W0_mask[b]) sram_mem[bus.W0_addr][8*b +: 8] <= bus.W0_data[8*b +: 8];
    if (bus.R0_en) sram_raddr_q <= bus.R0_addr;
  end
  assign bus.R0_data = sram_mem[sram_raddr_q];

  int n_checks = 0, n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: shadow memory, delivered-response queues, one pending read.
  logic [DW-1:0] mdl_mem [1024];
  logic [DW-1:0] mq0 [$];
  logic [DW-1:0] mq1 [$];
  bit            pend_v  = 1'b0;
  int            pend_id = 0;
  logic [DW-1:0] pend_d  = '0;
  int            m_wr_last = 1, m_rd_last = 1;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      sram_mem[i] = '0;
      mdl_mem[i]  = '0;
    end
  end

  function automatic logic [AW-1:0] in_addr(input int n);
    return (n == 0) ? bus.req0_addr : bus.req1_addr;
  endfunction
  function automatic logic [DW-1:0] in_data(input int n);
    return (n == 0) ? bus.req0_wdata : bus.req1_wdata;
  endfunction
  function automatic logic [MW-1:0] in_mask(input int n);
    return (n == 0) ? bus.req0_wmask : bus.req1_wmask;
  endfunction
  function automatic int outstanding(input int n);
    int q;
    q = (n == 0) ? mq0.size() : mq1.size();
    return q + ((pend_v && pend_id == n) ? 1 : 0);
  endfunction
  function automatic int pick(input bit c0, input bit c1, input int last);
    if (c0 && c1) return (last == 0) ? 1 : 0;
    if (c0) return 0;
    if (c1) return 1;
    return -1;
  endfunction

  function automatic void predict(output int ww, output int rw);
    bit wc0, wc1, rc0, rc1;
    ww = -1;
    rw = -1;
    if (!reset_n) return;
    wc0 = bus.req0_valid && bus.req0_write;
    wc1 = bus.req1_valid && bus.req1_write;
    rc0 = bus.req0_valid && !bus.req0_write && (outstanding(0) < DEPTH);
    rc1 = bus.req1_valid && !bus.req1_write && (outstanding(1) < DEPTH);
    ww  = pick(wc0, wc1, m_wr_last);
    rw  = pick(rc0, rc1, m_rd_last);
  endfunction

  task automatic model_step();
    int            ww, rw;
    logic [MW-1:0] m;
    logic [DW-1:0] d;
    logic [AW-1:0] a;
    predict(ww, rw);
    if (mq0.size() != 0 && bus.rsp0_ready) void'(mq0.pop_front());
    if (mq1.size() != 0 && bus.rsp1_ready) void'(mq1.pop_front());
    if (pend_v) begin
      if (pend_id == 0) mq0.push_back(pend_d);
      else              mq1.push_back(pend_d);
    end
    pend_v = 1'b0;
    if (ww >= 0) begin
      m = in_mask(ww);
      d = in_data(ww);
      a = in_addr(ww);
      for (int b = 0; b < MW; b++)
        if (m[b]) mdl_mem[a][8*b +: 8] = d[8*b +: 8];
    end
    if (rw >= 0) begin
      pend_v  = 1'b1;
      pend_id = rw;
      pend_d  = mdl_mem[in_addr(rw)];
    end
`ifndef SRAM_ARB_FIXED_PRIO_EN
    if (ww >= 0) m_wr_last = ww;
    if (rw >= 0) m_rd_last = rw;
`endif
  endtask

  initial forever begin
    @(posedge clock or negedge reset_n);
    if (!reset_n) begin
      mq0.delete();
      mq1.delete();
      pend_v    = 1'b0;
      m_wr_last = 1;
      m_rd_last = 1;
    end else begin
      model_step();
    end
  end

  task automatic compare_outputs();
    int          ww, rw;
    logic [1:0]  exp_rdy;
    logic [46:0] exp_w0;
    logic [10:0] exp_r0;
    logic [32:0] exp_rsp0, exp_rsp1;
    predict(ww, rw);
    exp_rdy = 2'b00;
    if (ww >= 0) exp_rdy[ww] = 1'b1;
    if (rw >= 0) exp_rdy[rw] = 1'b1;
    exp_w0   = (ww >= 0) ? {1'b1, in_mask(ww), in_addr(ww), in_data(ww)} : '0;
    exp_r0   = (rw >= 0) ? {1'b1, in_addr(rw)} : '0;
    exp_rsp0 = (mq0.size() != 0) ? {1'b1, mq0[0]} : '0;
    exp_rsp1 = (mq1.size() != 0) ? {1'b1, mq1[0]} : '0;
    check("req_ready", {bus.req1_ready, bus.req0_ready}, exp_rdy);
    check("w0_port", {bus.W0_en, bus.W0_mask, bus.W0_addr, bus.W0_data}, exp_w0);
    check("r0_port", {bus.R0_en, bus.R0_addr}, exp_r0);
    check("rsp0", {bus.rsp0_valid, bus.rsp0_rdata}, exp_rsp0);
    check("rsp1", {bus.rsp1_valid, bus.rsp1_rdata}, exp_rsp1);
  endtask

  initial forever begin
    @(negedge clock);
    compare_outputs();
  end

  task automatic drive(input int n, input bit v, input bit w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [MW-1:0] m);
    if (n == 0) begin
      bus.req0_valid = v; bus.req0_write = w; bus.req0_addr = a; bus.req0_wdata = d; bus.req0_wmask = m;
    end else begin
      bus.req1_valid = v; bus.req1_write = w; bus.req1_addr = a; bus.req1_wdata = d; bus.req1_wmask = m;
    end
  endtask

  task automatic idle();
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [7:0]    g0, g1;
    int            acc, pops;
    logic          seen, last_rdy;
    logic [AW-1:0] bp_addr [6];

    idle();
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    // A write held during reset must not reach the SRAM.
    drive(0, 1'b1, 1'b1, 10'h005, 32'hFFFF_FFFF, 4'hF);
    @(negedge clock);
    check("rst_ready", {bus.req1_ready, bus.req0_ready}, 2'b00);
    check("rst_sram", {bus.W0_en, bus.W0_addr, bus.W0_data, bus.W0_mask, bus.R0_en, bus.R0_addr}, '0);
    check("rst_rsp_valid", {bus.rsp1_valid, bus.rsp0_valid}, 2'b00);
    check("rst_rsp_rdata", {bus.rsp1_rdata, bus.rsp0_rdata}, '0);
    step(); idle(); step();
    reset_n = 1'b1;
    step();

    // Single read after a full write; latency 2 cycles.
    drive(0, 1'b1, 1'b1, 10'h005, 32'hDEADBEEF, 4'hF); step();
    drive(0, 1'b1, 1'b0, 10'h005, '0, '0);
    @(negedge clock); check("rd1_accept", bus.req0_ready, 1'b1);
    step(); idle();
    @(negedge clock); check("rd1_t1_valid", bus.rsp0_valid, 1'b0);
    step();
    @(negedge clock);
    check("rd1_t2_valid", bus.rsp0_valid, 1'b1);
    check("rd1_data", bus.rsp0_rdata, 32'hDEADBEEF);
    step();

    // Byte-masked write merge.
    drive(1, 1'b1, 1'b1, 10'h3FF, 32'h11223344, 4'hF); step();
    drive(1, 1'b1, 1'b1, 10'h3FF, 32'hAABBCCDD, 4'h5); step();
    drive(1, 1'b1, 1'b0, 10'h3FF, '0, '0); step();
    idle(); step();
    @(negedge clock); check("mask_rsp", {bus.rsp1_valid, bus.rsp1_rdata}, {1'b1, 32'h11BB33DD});
    step();

    // Read contention over 8 cycles.
    drive(0, 1'b1, 1'b1, 10'h010, 32'hA5A50010, 4'hF); step();
    drive(0, 1'b1, 1'b1, 10'h020, 32'h5A5A0020, 4'hF); step();
    for (int i = 0; i < 8; i++) begin
      drive(0, 1'b1, 1'b0, 10'h010, '0, '0);
      drive(1, 1'b1, 1'b0, 10'h020, '0, '0);
      @(negedge clock);
      g0[i] = bus.req0_ready;
      g1[i] = bus.req1_ready;
      step();
    end
    idle(); repeat (4) step();
`ifdef SRAM_ARB_FIXED_PRIO_EN
    check("contend_gnt0", g0, 8'hFF);
    check("contend_gnt1", g1, 8'h00);
`else
    check("contend_gnt0", g0, 8'h55);
    check("contend_gnt1", g1, 8'hAA);
`endif

    // Same-cycle write/read returns new data; write one cycle later leaves old data.
    drive(0, 1'b1, 1'b1, 10'h040, 32'hCAFEF00D, 4'hF);
    drive(1, 1'b1, 1'b0, 10'h040, '0, '0);
    @(negedge clock); check("haz_both_ready", {bus.req1_ready, bus.req0_ready}, 2'b11);
    step(); idle(); step();
    @(negedge clock); check("haz_new", {bus.rsp1_valid, bus.rsp1_rdata}, {1'b1, 32'hCAFEF00D});
    step();
    drive(1, 1'b1, 1'b0, 10'h040, '0, '0); step();
    idle(); drive(0, 1'b1, 1'b1, 10'h040, 32'h12345678, 4'hF); step();
    idle();
    @(negedge clock); check("haz_old", {bus.rsp1_valid, bus.rsp1_rdata}, {1'b1, 32'hCAFEF00D});
    step();

    // Backpressure on requester 1.
    bus.rsp1_ready = 1'b0;
    acc = 0;
    last_rdy = 1'b1;
    bp_addr = '{10'h010, 10'h020, 10'h040, 10'h3FF, 10'h005, 10'h010};
    for (int i = 0; i < 6; i++) begin
      drive(1, 1'b1, 1'b0, bp_addr[i], '0, '0);
      @(negedge clock);
      acc += int'(bus.req1_ready);
      last_rdy = bus.req1_ready;
      step();
    end
    check("bp_accepted", acc, 3);
    check("bp_stalled", last_rdy, 1'b0);
    drive(1, 1'b1, 1'b1, 10'h050, 32'h0BADF00D, 4'hF);
    @(negedge clock); check("bp_write_ok", bus.req1_ready, 1'b1);
    step();
    idle();
    bus.rsp1_ready = 1'b1;
    pops = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (i == 0) check("bp_head", bus.rsp1_rdata, 32'hA5A50010);
      pops += int'(bus.rsp1_valid);
      step();
    end
    check("bp_drained", pops, 3);
    drive(1, 1'b1, 1'b0, 10'h050, '0, '0);
    @(negedge clock); check("bp_resume", bus.req1_ready, 1'b1);
    step(); idle(); repeat (3) step();

    // Reset while a read is in flight.
    drive(0, 1'b1, 1'b0, 10'h005, '0, '0);
    @(negedge clock); check("mid_accept", bus.req0_ready, 1'b1);
    step(); idle();
    reset_n = 1'b0;
    seen = 1'b0;
    repeat (2) begin
      @(negedge clock); seen |= bus.rsp0_valid; step();
    end
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clock); seen |= bus.rsp0_valid; step();
    end
    check("mid_no_rsp", seen, 1'b0);
    drive(0, 1'b1, 1'b0, 10'h005, '0, '0);
    @(negedge clock); check("post_accept", bus.req0_ready, 1'b1);
    step(); idle(); step();
    @(negedge clock); check("post_data", {bus.rsp0_valid, bus.rsp0_rdata}, {1'b1, 32'hDEADBEEF});
    step(); step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
